fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue. Fetches sequentially from imem,
// buffers {pc, instr} pairs in a circular queue, and flushes and redirects on a branch.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_a,
  input  logic [31:0]              imem_rd,
  input  logic                     branch_valid,
  input  logic [31:0]              branch_target,
  input  logic                     stall_d,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              instr_pcplus8,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc_mem  [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_target;

  // Handshake decode; a branch suppresses the push and discards any pop
  always_comb begin
    w_valid  = (r_count != CW'(0));
    w_pop    = w_valid && !stall_d;
    w_push   = !branch_valid && ((r_count < CW'(DEPTH)) || w_pop);
    w_target = branch_target & ~32'h0000_0003;
  end

  // Fetch pc, pointers and occupancy; branch flushes and redirects
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (branch_valid) begin
      r_fetch_pc <= w_target;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue storage; never cleared, masked by instr_valid on the read side
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
      r_ins_mem[r_wr_ptr] <= imem_rd;
    end
  end

  // Head-of-queue outputs, zero whenever the queue is empty
  always_comb begin
    imem_a        = r_fetch_pc;
    count         = r_count;
    instr_valid   = w_valid;
    instr         = 32'h0;
    instr_pc      = 32'h0;
    instr_pcplus8 = 32'h0;
    if (w_valid) begin
      instr         = r_ins_mem[r_rd_ptr];
      instr_pc      = r_pc_mem[r_rd_ptr];
      instr_pcplus8 = r_pc_mem[r_rd_ptr] + 32'd8;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random stall/branch traffic,
// compared every cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        stall_d;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus8;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_a        (imem_a),
    .imem_rd       (imem_rd),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .stall_d       (stall_d),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pcplus8 (instr_pcplus8),
    .count         (count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ 32'hC0DE_0000;
  endfunction

  assign imem_rd = mem_word(imem_a);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fpc;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc = RESET_PC;
  endtask

  // One clock edge of the reference behaviour
  task automatic model_step(input logic s, input logic b, input logic [31:0] t);
    int  n;
    bit  pop;
    bit  push;
    n   = m_q.size();
    pop = (n != 0) && !s;
    if (b) begin
      m_q.delete();
      m_fpc = {t[31:2], 2'b00};
    end else begin
      push = (n < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back('{pc: m_fpc, ins: mem_word(m_fpc)});
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic compare_outputs();
    chk("imem_a", imem_a, m_fpc);
    chk("count", 32'(count), 32'(m_q.size()));
    chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("instr", instr, m_q[0].ins);
      chk("instr_pc", instr_pc, m_q[0].pc);
      chk("instr_pcplus8", instr_pcplus8, m_q[0].pc + 32'd8);
    end
  endtask

  // Called at a falling edge: check, drive new inputs, advance model, wait a cycle
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    compare_outputs();
    stall_d       = s;
    branch_valid  = b;
    branch_target = t;
    model_step(s, b, t);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_imem_a"}, imem_a, RESET_PC);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc"}, instr_pc, 32'h0);
    chk({tag, "_pc8"}, instr_pcplus8, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset         = 1'b0;
    stall_d       = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;

    // Free-running fetch after reset release
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

    // Stall saturates the queue, then drains in order (with push-on-full-pop)
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
    chk("sat_count", 32'(count), 32'd4);
    chk("sat_imem_a", imem_a, 32'h10);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Branch while full and stalled
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0103);
    chk("br_count", 32'(count), 32'h0);
    chk("br_imem_a", imem_a, 32'h100);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // Back-to-back branches, then address wrap at the top of memory
    step(1'b0, 1'b1, 32'h0000_4000);
    step(1'b0, 1'b1, 32'h0000_5000);
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc8", instr_pcplus8, 32'h0000_0004);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // Asynchronous reset in mid-cycle with three entries queued
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    compare_outputs();
    #2 reset = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, $urandom);
    end
    compare_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
